// File: rtl/drum_pkg.sv
// Shared definitions for the drum pattern dump: FSM state encoding, ASCII glyphs, frame length.
package drum_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE       = 3'd0;
    localparam state_t ST_LOAD       = 3'd1;
    localparam state_t ST_STROBE     = 3'd2;
    localparam state_t ST_WAIT_BUSY  = 3'd3;
    localparam state_t ST_WAIT_READY = 3'd4;
    localparam state_t ST_DONE       = 3'd5;

    localparam logic [7:0] ASCII_K     = 8'h4B;
    localparam logic [7:0] ASCII_C     = 8'h43;
    localparam logic [7:0] ASCII_H     = 8'h48;
    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_DOT   = 8'h2E;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int unsigned FRAME_LEN = 41;

    function automatic logic [7:0] sample_char(input logic hit, input logic [7:0] ch);
        return hit ? ch : ASCII_DOT;
    endfunction

endpackage

// File: rtl/pattern_fmt.sv
// Maps a frame byte index onto its ASCII character for the captured pattern.
module pattern_fmt
    import drum_pkg::*;
(
    input  logic [31:0] snapshot,
    input  logic [5:0]  index,
    output logic [7:0]  tx_byte
);

    logic [2:0] step;
    logic [5:0] step_base;
    logic [2:0] pos;
    logic [3:0] mask;

    always_comb begin
        // Steps 0..6 are five bytes wide; step 7 carries CR LF and is six.
        if (index >= 6'd35) begin
            step = 3'd7;
        end else begin
            step = 3'(index / 6'd5);
        end
        step_base = 6'(step) * 6'd5;
        pos       = 3'(index - step_base);
        mask      = snapshot[{step, 2'b00} +: 4];
        case (pos)
            3'd0:    tx_byte = sample_char(mask[3], ASCII_K);
            3'd1:    tx_byte = sample_char(mask[2], ASCII_C);
            3'd2:    tx_byte = sample_char(mask[1], ASCII_H);
            3'd3:    tx_byte = sample_char(mask[0], ASCII_S);
            3'd4:    tx_byte = (step == 3'd7) ? ASCII_CR : ASCII_SPACE;
            default: tx_byte = ASCII_LF;
        endcase
    end

endmodule

// File: rtl/seq_pattern_tx.sv
// Dumps a 32-bit, 8-step drum pattern as a 41-byte ASCII frame through a strobe/ready UART port.
module seq_pattern_tx
    import drum_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] pattern,
    input  logic        txready,
    output logic [7:0]  txdata,
    output logic        txclk,
    output logic        busy,
    output logic        done
);

    localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    state_t            state_q, state_d;
    logic [5:0]        index_q, index_d;
    logic [31:0]       snap_q, snap_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [7:0]        fmt_byte;

    pattern_fmt u_fmt (
        .snapshot (snap_q),
        .index    (index_q),
        .tx_byte  (fmt_byte)
    );

    always_comb begin
        state_d = state_q;
        index_d = index_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    index_d = 6'd0;
                    snap_d  = pattern;
                end
            end
            ST_LOAD: begin
                if (txready) begin
                    state_d = ST_STROBE;
                end
            end
            ST_STROBE: begin
                state_d = ST_WAIT_BUSY;
                cnt_d   = '0;
            end
            ST_WAIT_BUSY: begin
                // A UART that never drops ready is assumed to have taken the byte.
                if (!txready || cnt_q == CntW'(ACK_TIMEOUT - 1)) begin
                    state_d = ST_WAIT_READY;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_WAIT_READY: begin
                if (txready) begin
                    if (index_q == 6'(FRAME_LEN - 1)) begin
                        state_d = ST_DONE;
                    end else begin
                        index_d = index_q + 6'd1;
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            index_q <= 6'd0;
            snap_q  <= 32'd0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs decode straight from state so an asynchronous reset silences them at once.
    always_comb begin
        busy   = (state_q == ST_LOAD) || (state_q == ST_STROBE) ||
                 (state_q == ST_WAIT_BUSY) || (state_q == ST_WAIT_READY);
        txclk  = (state_q == ST_STROBE);
        done   = (state_q == ST_DONE);
        txdata = busy ? fmt_byte : 8'h00;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
REQ-001 Parameter ACK_TIMEOUT, default 4: max clk cycles to wait for txready to fall after a txclk strobe.
REQ-002 clk  input  1  system clock (hz2m).
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  one-cycle request to dump the pattern.
REQ-005 pattern  input  32  step i sample mask at bits [4i+3:4i]; bit3 kick, bit2 clap, bit1 hihat, bit0 snare.
REQ-006 txready  input  1  UART transmitter idle; low while a byte is shifting.
REQ-007 txdata  output  8  byte presented to the UART.
REQ-008 txclk  output  1  one-cycle strobe; the UART latches txdata on it.
REQ-009 busy  output  1  high from frame accept until the last byte completes.
REQ-010 done  output  1  one-cycle pulse when the final byte is complete.

Function
REQ-011 The block SHALL snapshot pattern into an internal register on the cycle start is accepted; later pattern changes SHALL NOT affect the frame in flight.
REQ-012 The frame SHALL be 41 bytes: for steps 0..7, four chars in order kick, clap, hihat, snare; each step is followed by 0x20, except step 7, which is followed by 0x0D 0x0A.
REQ-013 Sample chars SHALL be 'K' 0x4B, 'C' 0x43, 'H' 0x48, 'S' 0x53 when the bit is set, else '.' 0x2E.
REQ-014 The FSM states SHALL be IDLE, LOAD, STROBE, WAIT_BUSY, WAIT_READY, DONE.
REQ-015 IDLE: start=1 -> LOAD, byte index 0, busy=1; start is ignored in every other state.
REQ-016 LOAD: txdata = char(index); go to STROBE only when txready=1, otherwise stay.
REQ-017 STROBE: txclk=1 for exactly one cycle with txdata stable; next state WAIT_BUSY.
REQ-018 WAIT_BUSY: txready=0 -> WAIT_READY; if ACK_TIMEOUT cycles elapse with txready=1 -> WAIT_READY (byte treated as accepted).
REQ-019 WAIT_READY: txready=1 -> index 40 goes to DONE, otherwise index+1 and LOAD.
REQ-020 DONE: done=1 for one cycle, busy=0, next state IDLE.
REQ-021 txdata SHALL hold its value from LOAD through WAIT_READY; txclk SHALL never be high two consecutive cycles.
REQ-022 The byte index SHALL be 6 bits and never exceed 40; the step number is index/5 for steps 0..6 and 7 for indices 35..40.
REQ-023 start arriving in DONE SHALL be ignored, and IDLE accepts start from the next cycle.

Reset
REQ-024 On reset, state=IDLE, txdata=0x00, txclk=0, busy=0, done=0, index=0, snapshot=0.
REQ-025 Reset mid-frame SHALL abort immediately with no further txclk, and done SHALL NOT pulse.

Structure
REQ-026 Package drum_pkg SHALL hold the FSM state enum, the ASCII constants (K,C,H,S,dot,space,CR,LF) and FRAME_LEN=41.
REQ-027 Combinational sub-module pattern_fmt (inputs snapshot and index; output byte) SHALL implement REQ-012/013; the FSM stays in seq_pattern_tx.

Verification
REQ-028 Pattern 0, start, UART model (txready low 3 cycles after each txclk) -> 41 bytes: "...." + 0x20 seven times, then "...." 0x0D 0x0A; done pulses once.
REQ-029 Step0=4'b1000, step7=4'b0001, others 0 -> bytes 0..4 'K' '.' '.' '.' 0x20; bytes 35..40 '.' '.' '.' 'S' 0x0D 0x0A.
REQ-030 Pattern changed and second start pulsed at byte 10 -> frame matches the original snapshot; exactly 41 txclk pulses; a single done.
REQ-031 txready stuck high -> each byte advances after 4 WAIT_BUSY cycles; 41 strobes; done asserted.
REQ-032 txready held low at start -> block stays in LOAD with txclk=0 until txready rises, then strobes byte 0.
REQ-033 Reset asserted after byte 20 -> txclk=0, busy=0, txdata=0x00, no done; a new start sends the full 41 bytes from index 0.
